servo_motion_ctrl: RTL and testbench
====================================

SERVO_MOTION_CTRL -- requirements
Module: servo_motion_ctrl

Interface
REQ-001 Parameters SHALL be: N_JOINTS, default 4, number of servo channels; FRAME_TICKS, default 500000, CLK cycles per 20 ms frame at 25 MHz; MIN_US, default 650, minimum pulse width in µs; MAX_US, default 2600, maximum pulse width in µs; HOME_US, default 1625, reset/home width in µs; STEP_US, default 10, maximum change per joint per frame in µs.
REQ-002 Ports SHALL be, clock and reset first:
- CLK, in, 1, 25 MHz system clock.
- RESETN, in, 1, synchronous active-low reset.
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, command accepted this cycle when high with cmd_valid.
- cmd_joint, in, 2, target joint index.
- cmd_us, in, 12, requested pulse width in µs.
- pulse_us, out, N_JOINTS*12, current width per joint; joint j occupies bits [12j+11:12j]; feeds the per-joint PWM generators.
- frame_tick, out, 1, one-cycle pulse at each frame boundary.
- settled, out, 1, high when every joint's current width equals its target.
- cmd_err, out, 1, one-cycle pulse when an accepted command is invalid.
REQ-003 Clocking and reset SHALL be one clock, CLK; reset RESETN SHALL be synchronous and active-low.

Function
REQ-004 The frame counter SHALL count 0..FRAME_TICKS-1 and wrap to 0; frame_tick SHALL be high in the cycle the count equals FRAME_TICKS-1.
REQ-005 The FSM SHALL have exactly two states, IDLE and STEP; reset state is IDLE.
REQ-006 cmd_ready SHALL be high only when state is IDLE and frame_tick is low.
- A command transfers when cmd_valid and cmd_ready are both high.
- cmd_valid high with cmd_ready low SHALL NOT be consumed; the requester holds it.
REQ-007 On transfer, cmd_us SHALL be clamped to [MIN_US, MAX_US] and written to target[cmd_joint] in the next cycle.
REQ-008 A transfer with cmd_joint >= N_JOINTS SHALL leave all targets unchanged and pulse cmd_err high one cycle later.
REQ-009 IDLE -> STEP SHALL occur on frame_tick.
- In STEP, one joint is processed per cycle, in index order 0..N_JOINTS-1.
- After the last joint, the FSM returns to IDLE; STEP lasts exactly N_JOINTS cycles.
REQ-010 Per processed joint, with d = target - current:
- |d| <= STEP_US: current := target.
- d > STEP_US: current := current + STEP_US.
- d < -STEP_US: current := current - STEP_US.
- All arithmetic SHALL be 13-bit signed, with no wrap.
REQ-011 pulse_us SHALL be registered and SHALL change only in STEP cycles, so each PWM frame sees a stable value.
REQ-012 settled SHALL be registered and reflect all current == target, updated every cycle.
REQ-013 A target written while a joint is mid-ramp SHALL take effect at that joint's next STEP slot; no intermediate value is discarded.
REQ-014 Back-to-back commands to the same joint SHALL resolve last-write-wins.
REQ-015 Because FRAME_TICKS > N_JOINTS + 1, STEP SHALL always complete before the next frame_tick.

Reset
REQ-016 While RESETN is low at a CLK edge, the block SHALL set:
- every current and target to HOME_US;
- frame counter to 0;
- state to IDLE;
- frame_tick, cmd_err and cmd_ready to 0;
- settled to 1.
REQ-017 Reset asserted mid-STEP SHALL abandon the sweep; the first frame_tick after release SHALL occur FRAME_TICKS cycles after release.

Structure
REQ-018 A shared package servo_pkg SHALL hold US_W=12, the MIN_US/MAX_US/HOME_US/STEP_US defaults, FRAME_TICKS, and the IDLE/STEP state encoding.
REQ-019 One sub-module, servo_frame_timer, SHALL implement the frame counter and frame_tick.
REQ-020 Per-joint ramp logic SHALL be shared: one stepping datapath, time-multiplexed over the joints by index.

Verification
REQ-021 Reset release: pulse_us = 4 x 1625, settled=1, cmd_ready=1 from the first cycle after release; frame_tick first at cycle 499999.
REQ-022 Command joint 1 to 1700: joint 1 reaches 1635, 1645, ... 1695, 1700 on successive frames (8 frames); settled goes high after the last step.
REQ-023 Clamp and error: cmd_us=100 on joint 2 gives target 650; cmd_us=4000 gives target 2600; cmd_joint=3 with N_JOINTS=3 gives a cmd_err pulse and no state change.
REQ-024 Collision: cmd_valid held high across frame_tick gives cmd_ready low for N_JOINTS+1 cycles; the command is accepted on the first IDLE cycle after STEP, and none is lost.
REQ-025 Retarget mid-ramp: joint 0 ramping 1625 -> 2000, retargeted to 1600 at value 1705, reverses downward: 1695 ... 1605, 1600.
REQ-026 Reset during STEP (pulse RESETN low at STEP cycle 2): all outputs return to their reset values, with no partial update visible afterward.

Source files
------------

// File: rtl/servo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : servo_pkg                                                 |
// | Purpose  : Shared constants for the servo motion controller: pulse   |
// |            width bus size, default timing/limit values, FSM state    |
// |            encoding and the command clamp helper.                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package servo_pkg;

    localparam int US_W            = 12;      // width of one pulse-width value
    localparam int DEF_MIN_US      = 650;
    localparam int DEF_MAX_US      = 2600;
    localparam int DEF_HOME_US     = 1625;
    localparam int DEF_STEP_US     = 10;
    localparam int DEF_FRAME_TICKS = 500000;  // 20 ms at 25 MHz

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] IDLE = 1'b0;
    localparam logic [STATE_W-1:0] STEP = 1'b1;

    // Limit a requested width to the legal servo range.
    function automatic logic [US_W-1:0] clamp_us(input logic [US_W-1:0] us,
                                                 input int lo,
                                                 input int hi);
        logic [US_W-1:0] lo_v;
        logic [US_W-1:0] hi_v;
        logic [US_W-1:0] res;
        lo_v = US_W'(lo);
        hi_v = US_W'(hi);
        res  = us;
        if (us < lo_v) begin
            res = lo_v;
        end else if (us > hi_v) begin
            res = hi_v;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_frame_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : servo_frame_timer                                         |
// | Purpose  : Free-running frame counter 0..FRAME_TICKS-1.              |
// | Ports    : CLK, RESETN (sync, active-low)                            |
// |            o_frame_tick - high while the count equals FRAME_TICKS-1  |
// |            o_tick_next  - frame_tick will be high next cycle         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
    input  logic CLK,
    input  logic RESETN,
    output logic o_frame_tick,
    output logic o_tick_next
);

    localparam int c_CW = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 2;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(FRAME_TICKS - 1);
    localparam logic [c_CW-1:0] c_PRE  = c_CW'(FRAME_TICKS - 2);

    logic [c_CW-1:0] r_count;
    logic            r_tick;

    // The tick is registered from the "one before last" count so that it
    // lines up exactly with the cycle in which the count is FRAME_TICKS-1.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + c_CW'(1);
            r_tick  <= (r_count == c_PRE);
        end
    end

    assign o_frame_tick = r_tick;
    assign o_tick_next  = (r_count == c_PRE);

endmodule
`default_nettype wire

// File: rtl/servo_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : servo_motion_ctrl                                         |
// | Purpose  : Rate-limited servo position controller. Commands set a    |
// |            clamped target per joint; once per frame every joint's    |
// |            current width moves toward its target by at most STEP_US, |
// |            one joint per cycle through a single shared datapath.     |
// | Ports    : CLK, RESETN (sync, active-low)                            |
// |            cmd_valid/cmd_ready/cmd_joint/cmd_us - command handshake  |
// |            pulse_us   - current width per joint (12 bits each)       |
// |            frame_tick - one-cycle pulse at each frame boundary       |
// |            settled    - all current widths equal their targets       |
// |            cmd_err    - pulse after an accepted out-of-range joint   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module servo_motion_ctrl
    import servo_pkg::*;
#(
    parameter int N_JOINTS    = 4,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int MIN_US      = DEF_MIN_US,
    parameter int MAX_US      = DEF_MAX_US,
    parameter int HOME_US     = DEF_HOME_US,
    parameter int STEP_US     = DEF_STEP_US
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_joint,
    input  logic [11:0]              cmd_us,
    output logic [N_JOINTS*12-1:0]   pulse_us,
    output logic                     frame_tick,
    output logic                     settled,
    output logic                     cmd_err
);

    localparam int c_IDX_W = (N_JOINTS > 1) ? $clog2(N_JOINTS) : 1;
    localparam int c_SW    = US_W + 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_JOINTS - 1);
    // Bit k set when joint index k exists; the 2-bit index can name 4.
    localparam logic [3:0] c_JOINT_MASK =
        (N_JOINTS >= 4) ? 4'hF : 4'((1 << N_JOINTS) - 1);
    localparam logic [US_W-1:0]        c_HOME   = US_W'(HOME_US);
    localparam logic [US_W-1:0]        c_STEP   = US_W'(STEP_US);
    localparam logic signed [c_SW-1:0] c_STEP_S = c_SW'(STEP_US);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic               w_step_en;
    logic               w_tick;
    logic               w_tick_nxt;
    logic               r_ready;
    logic               r_err;
    logic               r_settled;
    logic               w_xfer;
    logic               w_joint_ok;
    logic [US_W-1:0]    w_cmd_clamped;
    logic [US_W-1:0]    w_cur_arr [N_JOINTS];
    logic [US_W-1:0]    w_tgt_arr [N_JOINTS];
    logic [US_W-1:0]    w_cur_sel;
    logic [US_W-1:0]    w_tgt_sel;
    logic [US_W-1:0]    w_new;
    logic signed [c_SW-1:0] w_diff;
    logic [N_JOINTS-1:0] w_eq;

    servo_frame_timer #(
        .FRAME_TICKS (FRAME_TICKS)
    ) u_timer (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .o_frame_tick (w_tick),
        .o_tick_next  (w_tick_nxt)
    );

    assign w_xfer        = cmd_valid && r_ready;
    assign w_joint_ok    = c_JOINT_MASK[cmd_joint];
    assign w_cmd_clamped = clamp_us(cmd_us, MIN_US, MAX_US);

    // Shared ramp datapath: the joint selected by r_idx is stepped.
    assign w_cur_sel = w_cur_arr[r_idx];
    assign w_tgt_sel = w_tgt_arr[r_idx];

    always_comb begin
        w_diff = $signed({1'b0, w_tgt_sel}) - $signed({1'b0, w_cur_sel});
        if (w_diff > c_STEP_S) begin
            w_new = w_cur_sel + c_STEP;
        end else if (w_diff < -c_STEP_S) begin
            w_new = w_cur_sel - c_STEP;
        end else begin
            w_new = w_tgt_sel;
        end
    end

    for (genvar j = 0; j < N_JOINTS; j++) begin : g_joint
        logic [US_W-1:0] r_cur;
        logic [US_W-1:0] r_tgt;

        // Commands only transfer in IDLE, so a target write and a ramp
        // step never hit the same joint in the same cycle.
        always_ff @(posedge CLK) begin
            if (!RESETN) begin
                r_cur <= c_HOME;
                r_tgt <= c_HOME;
            end else begin
                if (w_step_en && (r_idx == c_IDX_W'(j))) begin
                    r_cur <= w_new;
                end
                if (w_xfer && w_joint_ok && (cmd_joint == 2'(j))) begin
                    r_tgt <= w_cmd_clamped;
                end
            end
        end

        assign w_cur_arr[j]            = r_cur;
        assign w_tgt_arr[j]            = r_tgt;
        assign w_eq[j]                 = (r_cur == r_tgt);
        assign pulse_us[j*12 +: 12]    = r_cur;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_step_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    w_state_nxt = STEP;
                    w_idx_nxt   = '0;
                end
            end
            STEP: begin
                w_step_en = 1'b1;
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + c_IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // cmd_ready is registered from next-cycle state and tick so it stays
    // low through the tick cycle and the whole STEP sweep.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_settled <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_ready   <= (w_state_nxt == IDLE) && !w_tick_nxt;
            r_err     <= w_xfer && !w_joint_ok;
            r_settled <= &w_eq;
        end
    end

    assign cmd_ready  = r_ready;
    assign cmd_err    = r_err;
    assign settled    = r_settled;
    assign frame_tick = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_servo_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_servo_motion_ctrl                                      |
// | Purpose  : Self-checking bench for servo_motion_ctrl. Two instances  |
// |            (4 and 3 joints) share stimulus; a frame-level model of   |
// |            the controller is compared against both every cycle, and  |
// |            directed scenarios pin the model with literal values.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_servo_motion_ctrl;

    localparam int F    = 24;
    localparam int HOME = 1625;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_joint = 2'd0;
    logic [11:0] cmd_us = 12'd0;
    logic [47:0] pulse4;
    logic [35:0] pulse3;
    logic        tick4, tick3, set4, set3, rdy4, rdy3, err4, err3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    servo_motion_ctrl #(.N_JOINTS(4), .FRAME_TICKS(F)) u_dut4 (
        .CLK(CLK), .RESETN(RESETN), .cmd_valid(cmd_valid), .cmd_ready(rdy4),
        .cmd_joint(cmd_joint), .cmd_us(cmd_us), .pulse_us(pulse4),
        .frame_tick(tick4), .settled(set4), .cmd_err(err4));

    servo_motion_ctrl #(.N_JOINTS(3), .FRAME_TICKS(F)) u_dut3 (
        .CLK(CLK), .RESETN(RESETN), .cmd_valid(cmd_valid), .cmd_ready(rdy3),
        .cmd_joint(cmd_joint), .cmd_us(cmd_us), .pulse_us(pulse3),
        .frame_tick(tick3), .settled(set3), .cmd_err(err3));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame position m_cnt; a joint j is serviced in the cycle with
    // m_cnt == j of every frame that follows a frame_tick.
    int m_cur [2][4];
    int m_tgt [2][4];
    bit m_err [2];
    bit m_set [2];
    bit m_rdy [2];
    bit m_tick, m_armed, m_live;
    int m_cnt;

    function automatic int nj(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int clampv(input int us);
        return (us < 650) ? 650 : ((us > 2600) ? 2600 : us);
    endfunction

    task automatic model_step();
        if (!RESETN) begin
            m_cnt = 0; m_tick = 0; m_armed = 0; m_live = 1;
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < 4; j++) begin
                    m_cur[k][j] = HOME;
                    m_tgt[k][j] = HOME;
                end
                m_err[k] = 0; m_set[k] = 1; m_rdy[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit step, xfer, eq;
                int d;
                step = m_armed && (m_cnt < nj(k));
                xfer = cmd_valid && m_rdy[k];
                eq = 1;
                for (int j = 0; j < nj(k); j++) if (m_cur[k][j] != m_tgt[k][j]) eq = 0;
                m_set[k] = eq;
                if (step) begin
                    d = m_tgt[k][m_cnt] - m_cur[k][m_cnt];
                    if (d > 10)       m_cur[k][m_cnt] = m_cur[k][m_cnt] + 10;
                    else if (d < -10) m_cur[k][m_cnt] = m_cur[k][m_cnt] - 10;
                    else              m_cur[k][m_cnt] = m_tgt[k][m_cnt];
                end
                m_err[k] = xfer && (int'(cmd_joint) >= nj(k));
                if (xfer && (int'(cmd_joint) < nj(k)))
                    m_tgt[k][cmd_joint] = clampv(int'(cmd_us));
            end
            if (m_tick) m_armed = 1;
            m_cnt  = (m_cnt == F - 1) ? 0 : m_cnt + 1;
            m_tick = (m_cnt == F - 1);
            for (int k = 0; k < 2; k++)
                m_rdy[k] = !(m_armed && (m_cnt < nj(k))) && !m_tick;
        end
    endtask

    initial m_live = 0;
    always @(posedge CLK) model_step();

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (m_live) begin
            for (int j = 0; j < 4; j++)
                check($sformatf("pulse4[%0d]", j), 64'(pulse4[12*j +: 12]), 64'(m_cur[0][j]));
            for (int j = 0; j < 3; j++)
                check($sformatf("pulse3[%0d]", j), 64'(pulse3[12*j +: 12]), 64'(m_cur[1][j]));
            check("tick4", 64'(tick4), 64'(m_tick));
            check("tick3", 64'(tick3), 64'(m_tick));
            check("settled4", 64'(set4), 64'(m_set[0]));
            check("settled3", 64'(set3), 64'(m_set[1]));
            check("ready4", 64'(rdy4), 64'(m_rdy[0]));
            check("ready3", 64'(rdy3), 64'(m_rdy[1]));
            check("err4", 64'(err4), 64'(m_err[0]));
            check("err3", 64'(err3), 64'(m_err[1]));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_tick();
        for (int i = 0; i < 3 * F; i++) begin
            @(negedge CLK);
            if (tick4) break;
        end
        check("wait_tick", 64'(tick4), 64'd1);
    endtask

    // Returns in the first IDLE cycle after the next sweep.
    task automatic wait_frame();
        wait_tick();
        repeat (5) @(negedge CLK);
    endtask

    task automatic send(input int j, input int us);
        cmd_valid = 1'b1;
        cmd_joint = 2'(j);
        cmd_us    = 12'(us);
        for (int i = 0; i < 4 * F && !rdy4; i++) @(negedge CLK);
        check("send_ready", 64'(rdy4), 64'd1);
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    // Called in the first cycle after the last reset edge.
    task automatic release_checks();
        int n;
        RESETN = 1'b1;
        check("rst_pulse4", 64'(pulse4), {16'd0, {4{12'd1625}}});
        check("rst_pulse3", 64'(pulse3), {28'd0, {3{12'd1625}}});
        check("rst_settled", 64'(set4), 64'd1);
        check("rst_ready", 64'(rdy4), 64'd0);
        check("rst_tick", 64'(tick4), 64'd0);
        check("rst_err", 64'(err4), 64'd0);
        n = 0;
        for (int i = 1; i < 2 * F; i++) begin
            @(negedge CLK);
            if (i == 1) check("ready_after_release", 64'(rdy4), 64'd1);
            if (tick4) begin
                n = i;
                break;
            end
        end
        check("first_tick_cycle", 64'(n), 64'(F - 1));
    endtask

    initial begin
        int lows4, lows3;
        bit done3;

        repeat (3) @(negedge CLK);
        release_checks();

        // Joint 1 ramp 1625 -> 1700.
        send(1, 1700);
        for (int s = 0; s < 8; s++) begin
            wait_frame();
            check("ramp_j1", 64'(pulse4[23:12]), 64'((s < 7) ? 1635 + 10 * s : 1700));
            if (s == 6) check("ramp_unsettled", 64'(set4), 64'd0);
        end
        check("ramp_settled", 64'(set4), 64'd1);

        // Retarget joint 0 mid-ramp.
        send(0, 2000);
        for (int s = 0; s < 8; s++) wait_frame();
        check("retarget_at", 64'(pulse4[11:0]), 64'd1705);
        send(0, 1600);
        for (int s = 0; s < 11; s++) begin
            wait_frame();
            check("retarget_down", 64'(pulse4[11:0]),
                  64'(((1695 - 10 * s) < 1600) ? 1600 : (1695 - 10 * s)));
        end
        check("retarget_settled", 64'(set4), 64'd1);

        // Clamping and out-of-range joint.
        send(2, 100);
        wait_frame();
        check("clamp_low", 64'(pulse4[35:24]), 64'd1615);
        send(2, 4000);
        wait_frame();
        check("clamp_high", 64'(pulse4[35:24]), 64'd1625);
        send(3, 1234);
        check("err3_pulse", 64'(err3), 64'd1);
        check("err4_none", 64'(err4), 64'd0);
        @(negedge CLK);
        check("err3_one_cycle", 64'(err3), 64'd0);

        // Command held across frame_tick.
        wait_tick();
        cmd_valid = 1'b1; cmd_joint = 2'd1; cmd_us = 12'd900;
        lows4 = 0; lows3 = 0; done3 = 0;
        for (int i = 0; i < 4 * F && !rdy4; i++) begin
            if (rdy3) done3 = 1;
            else if (!done3) lows3++;
            lows4++;
            @(negedge CLK);
        end
        check("collide_low4", 64'(lows4), 64'd5);
        check("collide_low3", 64'(lows3), 64'd4);
        @(negedge CLK);
        cmd_valid = 1'b0;
        wait_frame();
        check("collide_j1_4", 64'(pulse4[23:12]), 64'd1690);
        check("collide_j1_3", 64'(pulse3[23:12]), 64'd1690);

        // Reset in the third STEP cycle.
        wait_tick();
        repeat (3) @(negedge CLK);
        RESETN = 1'b0;
        @(negedge CLK);
        release_checks();

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            cmd_valid = ($urandom % 2) == 1;
            cmd_joint = 2'($urandom % 4);
            cmd_us    = ($urandom % 2 == 1) ? 12'($urandom % 4096)
                                            : 12'(600 + $urandom_range(0, 2100));
            RESETN    = ($urandom % 700) != 0;
            @(negedge CLK);
        end
        RESETN = 1'b1;
        cmd_valid = 1'b0;
        repeat (2 * F) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
